systolic_8x8_seq_ctrl: RTL and testbench
========================================

// Module: systolic_8x8_seq_ctrl
// PURPOSE
//   Job sequencer for the 8x8 output-stationary systolic array.
//   On a start request it clears the array accumulators and streams k_len operand
//   vectors of A and B from the operand buffers into the array, skewed per lane.
//   It then drains the pipeline and signals done with the 8x8 C result valid and held.
//   Sits between the LSTM gate scheduler (start/done) and the array plus operand SRAMs.
// PARAMETERS
//   DATA_WIDTH  8   operand element width; must match the array data_width
//   K_WIDTH     8   width of k_len and rd_addr; max job length 2**K_WIDTH-1
//   DRAIN       16  post-feed cycles: 1 read latency + 7 skew + 7 propagation + 1 PE reg
// PORTS
//   clk_buf    in   1            clock
//   rst        in   1            asynchronous reset, active-high
//   start      in   1            job request; sampled only in IDLE
//   k_len      in   K_WIDTH      number of accumulation steps; captured with start
//   busy       out  1            high in every state except IDLE
//   done       out  1            one-cycle pulse when the C result is final
//   rd_en      out  1            operand buffer read strobe
//   rd_addr    out  K_WIDTH      operand buffer address, 0..k_len-1
//   a_rd_data  in   8*DATA_WIDTH A column vector; valid 1 cycle after rd_en
//   b_rd_data  in   8*DATA_WIDTH B row vector; valid 1 cycle after rd_en
//   arr_rst    out  1            drives array rst; clears accumulators
//   arr_en     out  1            drives array en
//   a_in_flat  out  8*DATA_WIDTH skewed A lanes to the array
//   b_in_flat  out  8*DATA_WIDTH skewed B lanes to the array
// BEHAVIOUR
//   Reset: state=IDLE. busy, done, rd_en, arr_rst and arr_en are 0. rd_addr=0.
//     All skew registers are 0, so a_in_flat=b_in_flat=0. Reset is asynchronous.
//   FSM transitions:
//     IDLE  -> CLEAR on start. Latch k_len into k_reg.
//     CLEAR: 2 cycles with arr_rst=1; this covers the array's registered reset sync.
//            Then go to FEED if k_reg!=0, otherwise to DONE.
//     FEED:  k_reg cycles. rd_en=1, rd_addr counts 0..k_reg-1, arr_en=1.
//     DRAIN: DRAIN cycles. rd_en=0, arr_en=1, skew lanes fill with zeros.
//     DONE:  1 cycle with done=1 and arr_en=0. Then return to IDLE.
//   Skew: lane i of A and lane i of B are delayed by i cycles through shift registers.
//     Lane 0 passes rd_data registered once. Shift registers advance every cycle.
//     A lane's shift register loads rd_data when the read issued one cycle earlier was
//     valid; it loads 0 otherwise.
//   Latency: start is seen at cycle 0. arr_rst is high in cycles 1-2. FEED runs in
//     cycles 3..k+2. done is high in cycle k+19; with k=0, done is high in cycle 3.
//   Result hold: arr_en=0 from DONE onward. C stays stable until the next job's CLEAR.
//   start while busy: ignored, with no queuing; k_len is not re-sampled.
//   start in the same cycle as done: ignored, because the FSM is not yet in IDLE.
//   Back-to-back jobs: the earliest accepted start is in the cycle after done.
//   Reset mid-job: all outputs return to reset values at once. Any partial C is invalid.
//     done is not asserted.
//   rd_addr width: no wrap occurs, because the FEED count is bounded by k_reg.
// TESTING
//   Identity test: k_len=8, A=I, B[r][c]=r*8+c. Require done at start+27 and C==B.
//   Minimum job: k_len=1, a=all 2, b=all 3. Require every C element = 6 and done at start+20.
//   Zero length: k_len=0. Require arr_rst for 2 cycles, no rd_en pulse, done at start+3,
//     and C all 0.
//   Busy start: pulse start again during FEED with k_len=5, first job k_len=8.
//     Require the first job's result only and one done.
//   Reset mid-FEED: assert rst at cycle 6. Require busy=0 and all outputs at reset values.
//     A following k_len=2 job must produce the correct C.
//   Back-to-back: job1 all 1s with k=4, then start in the cycle after done, job2 all 1s
//     with k=3. Require C=4 and then C=3, showing no carry-over.

Source files
------------

// File: rtl/systolic_8x8_seq_ctrl.sv
// rtl/systolic_8x8_seq_ctrl.sv - job sequencer for the 8x8 output-stationary systolic array
//
// Clears the array, streams k_len skewed A/B operand vectors, drains the pipeline
// and pulses done once the C result is final and held.
//
// Ports:
//   clk_buf, rst          clock, asynchronous active-high reset
//   start, k_len          job request (sampled in IDLE only) and accumulation length
//   busy, done            high outside IDLE; one-cycle result-ready pulse
//   rd_en, rd_addr        operand buffer read strobe and address (0..k_len-1)
//   a_rd_data, b_rd_data  A column / B row vectors, valid one cycle after rd_en
//   arr_rst, arr_en       array accumulator clear and enable
//   a_in_flat, b_in_flat  per-lane skewed operands into the array
module systolic_8x8_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int K_WIDTH    = 8,
    parameter int DRAIN      = 16
) (
    input  logic                    clk_buf,
    input  logic                    rst,
    input  logic                    start,
    input  logic [K_WIDTH-1:0]      k_len,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [K_WIDTH-1:0]      rd_addr,
    input  logic [8*DATA_WIDTH-1:0] a_rd_data,
    input  logic [8*DATA_WIDTH-1:0] b_rd_data,
    output logic                    arr_rst,
    output logic                    arr_en,
    output logic [8*DATA_WIDTH-1:0] a_in_flat,
    output logic [8*DATA_WIDTH-1:0] b_in_flat
);

    localparam int CNT_W = $clog2(DRAIN) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state, state_next;
    logic [K_WIDTH-1:0] k_reg;
    logic [K_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]   cnt;
    logic               rd_valid_q;

    // State register plus the per-state counters. cnt times CLEAR and DRAIN and
    // restarts from 0 on every state change; addr_q doubles as the FEED counter.
    always_ff @(posedge clk_buf or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            k_reg      <= '0;
            addr_q     <= '0;
            cnt        <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state      <= state_next;
            rd_valid_q <= rd_en;
            if (state == S_IDLE && start)
                k_reg <= k_len;
            if (state_next != state)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (state == S_FEED && state_next == S_FEED)
                addr_q <= addr_q + 1'b1;
            else
                addr_q <= '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_CLEAR;
            S_CLEAR: if (cnt == CNT_W'(1))
                         state_next = (k_reg != '0) ? S_FEED : S_DONE;
            S_FEED:  if (addr_q == k_reg - 1'b1) state_next = S_DRAIN;
            S_DRAIN: if (cnt == CNT_W'(DRAIN - 1)) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        rd_en   = (state == S_FEED);
        arr_rst = (state == S_CLEAR);
        arr_en  = (state == S_FEED) || (state == S_DRAIN);
        rd_addr = addr_q;
    end

    // Lane i is a shift register of depth i+1: lane 0 is the read data registered
    // once, each further lane adds one cycle of skew. Stage 0 takes zeros whenever
    // the previous cycle issued no read, so the drain phase flushes zeros.
    for (genvar i = 0; i < 8; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] a_sr [0:i];
        logic [DATA_WIDTH-1:0] b_sr [0:i];

        always_ff @(posedge clk_buf or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= i; j++) begin
                    a_sr[j] <= '0;
                    b_sr[j] <= '0;
                end
            end else begin
                a_sr[0] <= rd_valid_q ? a_rd_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                b_sr[0] <= rd_valid_q ? b_rd_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int j = 1; j <= i; j++) begin
                    a_sr[j] <= a_sr[j-1];
                    b_sr[j] <= b_sr[j-1];
                end
            end
        end

        assign a_in_flat[i*DATA_WIDTH +: DATA_WIDTH] = a_sr[i];
        assign b_in_flat[i*DATA_WIDTH +: DATA_WIDTH] = b_sr[i];
    end

endmodule

// File: tb/tb_systolic_8x8_seq_ctrl.sv
// tb/tb_systolic_8x8_seq_ctrl.sv - self-checking bench for systolic_8x8_seq_ctrl
module tb_systolic_8x8_seq_ctrl;

    logic        clk_buf = 1'b0;
    logic        rst     = 1'b1;
    logic        start   = 1'b0;
    logic [7:0]  k_len   = '0;
    logic        busy, done, rd_en, arr_rst, arr_en;
    logic [7:0]  rd_addr;
    logic [63:0] a_rd_data, b_rd_data;
    logic [63:0] a_in_flat, b_in_flat;

    systolic_8x8_seq_ctrl dut (
        .clk_buf   (clk_buf),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .a_rd_data (a_rd_data),
        .b_rd_data (b_rd_data),
        .arr_rst   (arr_rst),
        .arr_en    (arr_en),
        .a_in_flat (a_in_flat),
        .b_in_flat (b_in_flat)
    );

    always #5 clk_buf = ~clk_buf;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int c0        = 0;

    always @(posedge clk_buf) cyc <= cyc + 1;

    // Operand buffers: one-cycle read latency.
    logic [63:0] a_mem [256];
    logic [63:0] b_mem [256];
    always @(posedge clk_buf) begin
        if (rd_en) begin
            a_rd_data <= a_mem[rd_addr];
            b_rd_data <= b_mem[rd_addr];
        end
    end

    // Reference output-stationary array: A flows right, B flows down.
    int         acc [8][8];
    logic [7:0] ap  [8][8];
    logic [7:0] bp  [8][8];

    function automatic logic [7:0] a_at(int r, int c);
        if (c == 0) return a_in_flat[r*8 +: 8];
        return ap[r][c-1];
    endfunction

    function automatic logic [7:0] b_at(int r, int c);
        if (r == 0) return b_in_flat[c*8 +: 8];
        return bp[r-1][c];
    endfunction

    always @(posedge clk_buf) begin
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (arr_rst) begin
                    acc[r][c] <= 0;
                    ap[r][c]  <= '0;
                    bp[r][c]  <= '0;
                end else if (arr_en) begin
                    acc[r][c] <= acc[r][c] + int'(a_at(r, c)) * int'(b_at(r, c));
                    ap[r][c]  <= a_at(r, c);
                    bp[r][c]  <= b_at(r, c);
                end
            end
        end
    end

    // Event counters sampled mid-high-phase, away from both edges.
    int arr_rst_seen = 0;
    int rd_en_seen   = 0;
    int done_seen    = 0;
    always @(posedge clk_buf) begin
        #2;
        arr_rst_seen += int'(arr_rst);
        rd_en_seen   += int'(rd_en);
        done_seen    += int'(done);
    end

    logic [2047:0] exp_c_q    [$];
    int            exp_done_q [$];

    function automatic logic [2047:0] c_actual();
        logic [2047:0] v;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                v[(r*8+c)*32 +: 32] = acc[r][c];
        return v;
    endfunction

    function automatic logic [2047:0] c_model(int k);
        logic [2047:0] v;
        int s;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                s = 0;
                for (int kk = 0; kk < k; kk++)
                    s += int'(a_mem[kk][r*8 +: 8]) * int'(b_mem[kk][c*8 +: 8]);
                v[(r*8+c)*32 +: 32] = s;
            end
        return v;
    endfunction

    task automatic fill_const(int k, logic [7:0] av, logic [7:0] bv);
        for (int kk = 0; kk < k; kk++)
            for (int l = 0; l < 8; l++) begin
                a_mem[kk][l*8 +: 8] = av;
                b_mem[kk][l*8 +: 8] = bv;
            end
    endtask

    // Issues a one-cycle start; when sb is set the expected C and done cycle are queued.
    task automatic launch(int k, bit sb);
        @(negedge clk_buf);
        k_len = 8'(k);
        start = 1'b1;
        c0    = cyc;
        if (sb) begin
            exp_c_q.push_back(c_model(k));
            exp_done_q.push_back(c0 + ((k == 0) ? 3 : k + 19));
        end
        @(negedge clk_buf);
        start = 1'b0;
    endtask

    task automatic wait_done(string name);
        bit            got;
        logic [2047:0] ec;
        int            ed;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk_buf);
            if (done === 1'b1) got = 1'b1;
        end
        total_cnt++;
        if (!got || exp_c_q.size() == 0) begin
            $display("FAIL %s_done_seen: got=%0d queued=%0d required done with queued result",
                     name, got, exp_c_q.size());
            return;
        end
        pass_cnt++;
        ec = exp_c_q.pop_front();
        ed = exp_done_q.pop_front();
        total_cnt++;
        if (cyc !== ed)
            $display("FAIL %s_done_cycle: actual=%0d required=%0d", name, cyc - c0, ed - c0);
        else
            pass_cnt++;
        total_cnt++;
        if (c_actual() !== ec) begin
            for (int e = 0; e < 64; e++)
                if (c_actual()[e*32 +: 32] !== ec[e*32 +: 32]) begin
                    $display("FAIL %s_c: C[%0d][%0d] actual=%0d required=%0d", name,
                             e / 8, e % 8, c_actual()[e*32 +: 32], ec[e*32 +: 32]);
                    break;
                end
        end else
            pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk_buf);
        total_cnt++;
        if ({busy, done, rd_en, arr_rst, arr_en} !== 5'b0)
            $display("FAIL reset_ctrl: actual=%b required=00000",
                     {busy, done, rd_en, arr_rst, arr_en});
        else pass_cnt++;
        total_cnt++;
        if (rd_addr !== 8'd0)
            $display("FAIL reset_rd_addr: actual=%0d required=0", rd_addr);
        else pass_cnt++;
        total_cnt++;
        if ({a_in_flat, b_in_flat} !== 128'd0)
            $display("FAIL reset_lanes: actual=%h required=0", {a_in_flat, b_in_flat});
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_identity();
        for (int kk = 0; kk < 8; kk++)
            for (int l = 0; l < 8; l++) begin
                a_mem[kk][l*8 +: 8] = (l == kk) ? 8'd1 : 8'd0;
                b_mem[kk][l*8 +: 8] = 8'(kk*8 + l);
            end
        launch(8, 1'b1);
        wait_done("identity");
    endtask

    task automatic test_min_job();
        fill_const(1, 8'd2, 8'd3);
        launch(1, 1'b1);
        wait_done("min_job");
    endtask

    task automatic test_zero_len();
        int ar0, rd0;
        ar0 = arr_rst_seen;
        rd0 = rd_en_seen;
        launch(0, 1'b1);
        wait_done("zero_len");
        total_cnt++;
        if (arr_rst_seen - ar0 !== 2)
            $display("FAIL zero_len_arr_rst: actual=%0d cycles required=2", arr_rst_seen - ar0);
        else pass_cnt++;
        total_cnt++;
        if (rd_en_seen - rd0 !== 0)
            $display("FAIL zero_len_rd_en: actual=%0d cycles required=0", rd_en_seen - rd0);
        else pass_cnt++;
    endtask

    task automatic test_busy_start();
        int d0;
        for (int kk = 0; kk < 8; kk++)
            for (int l = 0; l < 8; l++) begin
                a_mem[kk][l*8 +: 8] = 8'($urandom_range(0, 15));
                b_mem[kk][l*8 +: 8] = 8'($urandom_range(0, 15));
            end
        d0 = done_seen;
        launch(8, 1'b1);
        repeat (4) @(negedge clk_buf);
        k_len = 8'd5;
        start = 1'b1;
        @(negedge clk_buf);
        start = 1'b0;
        wait_done("busy_start");
        repeat (40) @(negedge clk_buf);
        total_cnt++;
        if (done_seen - d0 !== 1 || busy !== 1'b0)
            $display("FAIL busy_start_single: done_pulses=%0d busy=%b required 1 and 0",
                     done_seen - d0, busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_feed();
        fill_const(8, 8'd5, 8'd7);
        launch(8, 1'b0);
        repeat (5) @(negedge clk_buf);
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({busy, done, rd_en, arr_rst, arr_en} !== 5'b0 || rd_addr !== 8'd0)
            $display("FAIL mid_reset_ctrl: actual=%b addr=%0d required=00000 addr=0",
                     {busy, done, rd_en, arr_rst, arr_en}, rd_addr);
        else pass_cnt++;
        total_cnt++;
        if ({a_in_flat, b_in_flat} !== 128'd0)
            $display("FAIL mid_reset_lanes: actual=%h required=0", {a_in_flat, b_in_flat});
        else pass_cnt++;
        @(negedge clk_buf);
        rst = 1'b0;
        for (int kk = 0; kk < 2; kk++)
            for (int l = 0; l < 8; l++) begin
                a_mem[kk][l*8 +: 8] = 8'(l + kk + 1);
                b_mem[kk][l*8 +: 8] = 8'(2*l + 3*kk);
            end
        launch(2, 1'b1);
        wait_done("after_reset");
    endtask

    task automatic test_back_to_back();
        fill_const(4, 8'd1, 8'd1);
        launch(4, 1'b1);
        wait_done("b2b_job1");
        launch(3, 1'b1);
        wait_done("b2b_job2");
    endtask

    initial begin
        test_reset();
        test_identity();
        test_min_job();
        test_zero_len();
        test_busy_start();
        test_reset_mid_feed();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
